// File: rtl/gf2_pkg.sv
// Shared types and elaboration helpers for the folded GF(2) matrix-vector multiplier.
// Contents: FSM state encoding, a clog2 that never returns less than 1, and the
// compute-pass count (ceil(rows / rows_per_cycle)).
package gf2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Index width for n items, floored at 1 bit so a single-row matrix still has a port.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int calc_npass(input int rows, input int rows_per_cycle);
    return (rows + rows_per_cycle - 1) / rows_per_cycle;
  endfunction

endpackage

// File: rtl/gf2_row_dot.sv
// GF(2) dot product of one matrix row with a vector: parity of (row AND vector).
// Latency: combinational, no state.
// Backpressure: none; pure function of its inputs.
//   i_row : C-bit matrix row, bit c = M[row][c]
//   i_vec : C-bit vector operand
//   o_bit : product bit (0 for an all-zero row)
module gf2_row_dot #(
  parameter int C = 8
) (
  input  logic [C-1:0] i_row,
  input  logic [C-1:0] i_vec,
  output logic         o_bit
);

  assign o_bit = ^(i_row & i_vec);

endmodule

// File: rtl/gf2_matrix_multiply_seq.sv
// Folded, run-time-programmable GF(2) matrix-vector multiplier (out[r] = ^(M[r] & v)).
// Latency: input accept at edge t -> out_valid from edge t+NPASS; one vector per NPASS+2 cycles.
// Backpressure: in_ready low while busy or while a config write is presented; result held in DONE until out_ready.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : vector input handshake, in_vector is C bits
//   out_valid/out_ready   : result handshake, out_vector is R bits (bit r = row r)
//   cfg_we/cfg_ready      : row write (cfg_row, cfg_data); only honoured while idle
//   busy                  : a vector is in flight
module gf2_matrix_multiply_seq
  import gf2_pkg::*;
#(
  parameter int               C              = 8,
  parameter int               R              = C,
  parameter int               ROWS_PER_CYCLE = 1,
  parameter logic [R*C-1:0]   INIT_MATRIX    = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [C-1:0]              in_vector,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [R-1:0]              out_vector,
  input  logic                      cfg_we,
  output logic                      cfg_ready,
  input  logic [clog2_min1(R)-1:0]  cfg_row,
  input  logic [C-1:0]              cfg_data,
  output logic                      busy
);

  localparam int NPASS = calc_npass(R, ROWS_PER_CYCLE);
  localparam int RW    = clog2_min1(R);
  // row_base runs to NPASS*ROWS_PER_CYCLE, which may exceed R when the last pass is partial.
  localparam int BW    = clog2_min1(NPASS * ROWS_PER_CYCLE + 1);
  localparam logic [BW-1:0] LAST_BASE = BW'((NPASS - 1) * ROWS_PER_CYCLE);
  localparam logic [BW-1:0] STEP      = BW'(ROWS_PER_CYCLE);

  state_t                              r_state;
  logic [C-1:0]                        r_mat [R];
  logic [C-1:0]                        r_vec;
  logic [R-1:0]                        r_out;
  logic [BW-1:0]                       r_row_base;

  logic [ROWS_PER_CYCLE-1:0][BW-1:0]   w_idx;
  logic [ROWS_PER_CYCLE-1:0][C-1:0]    w_row;
  logic [ROWS_PER_CYCLE-1:0]           w_bit;
  logic [R-1:0]                        w_nxt;

  // Row select: lane k looks at row row_base+k; lanes past the last row see a zero row.
  always_comb begin
    w_idx = '0;
    w_row = '0;
    for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
      w_idx[k] = r_row_base + BW'(k);
      for (int r = 0; r < R; r++) begin
        if (w_idx[k] == BW'(r)) begin
          w_row[k] = r_mat[r];
        end
      end
    end
  end

  for (genvar k = 0; k < ROWS_PER_CYCLE; k++) begin : g_lane
    gf2_row_dot #(.C(C)) u_dot (
      .i_row (w_row[k]),
      .i_vec (r_vec),
      .o_bit (w_bit[k])
    );
  end

  // Merge this pass's lane results into the result; out-of-range lanes match no row.
  always_comb begin
    w_nxt = r_out;
    for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
      for (int r = 0; r < R; r++) begin
        if (w_idx[k] == BW'(r)) begin
          w_nxt[r] = w_bit[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_vec      <= '0;
      r_out      <= '0;
      r_row_base <= '0;
      for (int r = 0; r < R; r++) begin
        r_mat[r] <= INIT_MATRIX[r*C +: C];
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_we) begin
            // Indices >= R match no entry, so such writes are acknowledged and dropped.
            for (int r = 0; r < R; r++) begin
              if (cfg_row == RW'(r)) begin
                r_mat[r] <= cfg_data;
              end
            end
          end else if (in_valid) begin
            r_vec      <= in_vector;
            r_out      <= '0;
            r_row_base <= '0;
            r_state    <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          r_out      <= w_nxt;
          r_row_base <= r_row_base + STEP;
          if (r_row_base == LAST_BASE) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE) && !cfg_we;
  assign cfg_ready  = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE);
  assign out_vector = r_out;

endmodule

// File: tb/tb_gf2_matrix_multiply_seq.sv
// Bench for gf2_matrix_multiply_seq: a 4x4 single-row-per-cycle instance and a
// 5x5 two-rows-per-cycle instance, driven with directed vectors; expected results
// are queued at issue time and popped by per-instance output monitors.
module tb_gf2_matrix_multiply_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- 4x4, P=1 ----------------
  logic       in_valid4, in_ready4, out_valid4, out_ready4, cfg_we4, cfg_ready4, busy4;
  logic [3:0] in_vector4, out_vector4, cfg_data4;
  logic [1:0] cfg_row4;

  gf2_matrix_multiply_seq #(.C(4), .R(4), .ROWS_PER_CYCLE(1), .INIT_MATRIX(16'h8421)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_vector(in_vector4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_vector(out_vector4),
    .cfg_we(cfg_we4), .cfg_ready(cfg_ready4), .cfg_row(cfg_row4), .cfg_data(cfg_data4),
    .busy(busy4)
  );

  // ---------------- 5x5, P=2 ----------------
  logic       in_valid5, in_ready5, out_valid5, out_ready5, cfg_we5, cfg_ready5, busy5;
  logic [4:0] in_vector5, out_vector5, cfg_data5;
  logic [2:0] cfg_row5;

  gf2_matrix_multiply_seq #(.C(5), .R(5), .ROWS_PER_CYCLE(2), .INIT_MATRIX(25'h1041041)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid5), .in_ready(in_ready5), .in_vector(in_vector5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_vector(out_vector5),
    .cfg_we(cfg_we5), .cfg_ready(cfg_ready5), .cfg_row(cfg_row5), .cfg_data(cfg_data5),
    .busy(busy5)
  );

  // Scoreboards: expected result and the edge at which the input was accepted.
  logic [3:0] q4 [$];
  int         acc4 [$];
  bit         seen4 = 0;
  logic [4:0] q5 [$];
  int         acc5 [$];
  bit         seen5 = 0;

  always @(negedge clk) begin
    if (rst_n && out_valid4) begin
      if (q4.size() == 0) begin
        chk(0, "dut4_unexpected_output", 32'(out_vector4), 0);
      end else begin
        if (!seen4) begin
          chk(cyc - acc4[0] == 4, "dut4_latency", 32'(cyc - acc4[0]), 4);
          seen4 = 1;
        end
        chk(out_vector4 == q4[0], "dut4_out_vector", 32'(out_vector4), 32'(q4[0]));
        chk(in_ready4 == 1'b0, "dut4_in_ready_in_done", 32'(in_ready4), 0);
        if (out_ready4) begin
          void'(q4.pop_front());
          void'(acc4.pop_front());
          seen4 = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid5) begin
      if (q5.size() == 0) begin
        chk(0, "dut5_unexpected_output", 32'(out_vector5), 0);
      end else begin
        if (!seen5) begin
          chk(cyc - acc5[0] == 3, "dut5_latency", 32'(cyc - acc5[0]), 3);
          seen5 = 1;
        end
        chk(out_vector5 == q5[0], "dut5_out_vector", 32'(out_vector5), 32'(q5[0]));
        if (out_ready5) begin
          void'(q5.pop_front());
          void'(acc5.pop_front());
          seen5 = 0;
        end
      end
    end
  end

  // All driver tasks are entered and left just after a rising edge.
  task automatic send4(input logic [3:0] v, input logic [3:0] exp);
    int i;
    in_valid4  = 1'b1;
    in_vector4 = v;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready4) break;
    end
    if (i == 200) begin
      chk(0, "dut4_send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      return;
    end
    q4.push_back(exp);
    acc4.push_back(cyc + 1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  task automatic send5(input logic [4:0] v, input logic [4:0] exp);
    int i;
    in_valid5  = 1'b1;
    in_vector5 = v;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready5) break;
    end
    if (i == 200) begin
      chk(0, "dut5_send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid5 = 1'b0;
      return;
    end
    q5.push_back(exp);
    acc5.push_back(cyc + 1);
    @(posedge clk); #1;
    in_valid5 = 1'b0;
  endtask

  task automatic cfg4(input logic [1:0] row, input logic [3:0] data);
    cfg_we4 = 1'b1; cfg_row4 = row; cfg_data4 = data;
    @(negedge clk);
    chk(cfg_ready4 == 1'b1, "dut4_cfg_ready_idle", 32'(cfg_ready4), 1);
    chk(in_ready4 == 1'b0, "dut4_cfg_priority", 32'(in_ready4), 0);
    @(posedge clk); #1;
    cfg_we4 = 1'b0;
  endtask

  task automatic cfg5(input logic [2:0] row, input logic [4:0] data);
    cfg_we5 = 1'b1; cfg_row5 = row; cfg_data5 = data;
    @(negedge clk);
    chk(cfg_ready5 == 1'b1, "dut5_cfg_ready_idle", 32'(cfg_ready5), 1);
    @(posedge clk); #1;
    cfg_we5 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q4.size() != 0 || q5.size() != 0); i++) @(negedge clk);
    @(posedge clk); #1;
    chk(q4.size() == 0 && q5.size() == 0, "drain_timeout", 32'(q4.size() + q5.size()), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid4 = 0; in_vector4 = '0; out_ready4 = 1; cfg_we4 = 0; cfg_row4 = '0; cfg_data4 = '0;
    in_valid5 = 0; in_vector5 = '0; out_ready5 = 1; cfg_we5 = 0; cfg_row5 = '0; cfg_data5 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk(out_valid4 == 0 && busy4 == 0, "dut4_reset_valid_busy", {30'd0, out_valid4, busy4}, 0);
    chk(out_vector4 == 4'b0000, "dut4_reset_out_vector", 32'(out_vector4), 0);
    chk(in_ready4 == 1 && cfg_ready4 == 1, "dut4_reset_ready", {30'd0, in_ready4, cfg_ready4}, 3);
    chk(out_valid5 == 0 && out_vector5 == 5'd0, "dut5_reset_out", {26'd0, out_valid5, out_vector5}, 0);
    @(posedge clk); #1;

    // Identity matrix on both instances.
    send4(4'b1011, 4'b1011);
    send5(5'b10110, 5'b10110);
    drain();
    send5(5'b00001, 5'b00001);
    send5(5'b11111, 5'b11111);
    drain();

    // 5x5: program row 2 to all ones; a write to row 5 must be dropped.
    cfg5(3'd2, 5'b11111);
    send5(5'b01011, 5'b01111);
    drain();
    cfg5(3'd5, 5'b11111);
    send5(5'b10000, 5'b10100);
    drain();

    // 4x4: reprogram the whole matrix.
    cfg4(2'd0, 4'b1111);
    cfg4(2'd1, 4'b0011);
    cfg4(2'd2, 4'b0000);
    cfg4(2'd3, 4'b1000);
    send4(4'b0110, 4'b0010);
    send4(4'b1111, 4'b1000);
    drain();

    // Write attempt during COMPUTE is refused and must not disturb either vector.
    send4(4'b0110, 4'b0010);
    cfg_we4 = 1'b1; cfg_row4 = 2'd0; cfg_data4 = 4'b0100;
    @(negedge clk);
    chk(cfg_ready4 == 1'b0, "dut4_cfg_ready_compute", 32'(cfg_ready4), 0);
    chk(busy4 == 1'b1, "dut4_busy_compute", 32'(busy4), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cfg_we4 = 1'b0;
    drain();
    send4(4'b0001, 4'b0011);
    drain();

    // Output backpressure: hold in DONE for 10 cycles.
    out_ready4 = 1'b0;
    send4(4'b1001, 4'b1010);
    for (int i = 0; i < 50 && !out_valid4; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk(in_ready4 == 1'b1 && busy4 == 1'b0, "dut4_idle_after_handshake", {30'd0, in_ready4, busy4}, 2);
    chk(out_vector4 == 4'b1010, "dut4_out_held_idle", 32'(out_vector4), 32'(4'b1010));
    @(posedge clk); #1;
    drain();

    // Reset in the middle of a computation after a config write.
    cfg4(2'd1, 4'b1111);
    send4(4'b0011, 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk(out_valid4 == 0 && busy4 == 0, "dut4_midreset_valid_busy", {30'd0, out_valid4, busy4}, 0);
    chk(out_vector4 == 4'b0000, "dut4_midreset_out_vector", 32'(out_vector4), 0);
    q4.delete();
    acc4.delete();
    seen4 = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send4(4'b1011, 4'b1011);
    send4(4'b0011, 4'b0011);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: cycle %0d reached limit", cyc);
    $fatal(1);
  end

endmodule
